// File: rtl/fixed_point_accumulator.sv
// Sums each group of len signed Qn.d products into a widened accumulator, emits one saturated n-bit sum.
// Latency: send_val rises the cycle after the len-th product is accepted.
// Backpressure: recv_rdy is low while a result is pending; the result holds until send_rdy.
module fixed_point_accumulator #(
    parameter int n   = 32,
    parameter int d   = 16,
    parameter int len = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] recv_msg,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] send_msg,
    output logic         send_sat
);

    localparam int CW = $clog2(len) + 1;
    localparam int W  = n + $clog2(len) + 1;

    if (len < 1 || len > 256 || d < 0 || d >= n) begin : g_bad_cfg
        $error("fixed_point_accumulator: illegal n/d/len configuration");
    end

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] sum;
    logic [CW-1:0]       cnt_q;
    logic                recv_fire;
    logic                send_fire;
    logic                last;
    logic                ovf;
    logic [n-1:0]        sat_msg;

    assign recv_rdy  = (state_q == ACC);
    assign send_val  = (state_q == DONE);
    assign recv_fire = recv_val && recv_rdy;
    assign send_fire = send_val && send_rdy;
    assign last      = (cnt_q == CW'(len - 1));

    // Partial sums run in full width; only the final group sum is clipped,
    // so any intermediate wrap past n bits is harmless.
    assign sum = acc_q + {{(W-n){recv_msg[n-1]}}, recv_msg};

    // Result fits in n bits only when every bit from n-1 upward is a sign copy.
    assign ovf     = !((&sum[W-1:n-1]) || !(|sum[W-1:n-1]));
    assign sat_msg = !ovf      ? sum[n-1:0] :
                     sum[W-1]  ? {1'b1, {(n-1){1'b0}}} :
                                 {1'b0, {(n-1){1'b1}}};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (recv_fire && last) state_d = DONE;
            DONE:    if (send_fire)         state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            send_msg <= '0;
            send_sat <= 1'b0;
        end else if (recv_fire) begin
            acc_q <= sum;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                send_msg <= sat_msg;
                send_sat <= ovf;
            end
        end else if (send_fire) begin
            acc_q <= '0;
            cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Scoreboarded bench for fixed_point_accumulator with n=32, d=16, len=4.
module tb_fixed_point_accumulator;

    localparam int N   = 32;
    localparam int LEN = 4;

    logic         clk;
    logic         reset;
    logic         recv_val;
    logic         recv_rdy;
    logic [N-1:0] recv_msg;
    logic         send_val;
    logic         send_rdy;
    logic [N-1:0] send_msg;
    logic         send_sat;

    int checks   = 0;
    int failures = 0;

    logic [N:0] exp_q[$];

    logic         prev_stall;
    logic [N-1:0] prev_msg;
    logic         prev_sat;

    fixed_point_accumulator #(.n(N), .d(16), .len(LEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .recv_msg (recv_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .send_msg (send_msg),
        .send_sat (send_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one product and hold it until it is accepted; returns 1ns after the fire edge.
    task automatic push(input logic [N-1:0] m);
        logic fired;
        fired    = 1'b0;
        recv_val = 1'b1;
        recv_msg = m;
        for (int k = 0; k < 200 && !fired; k++) begin
            fired = recv_rdy;
            @(posedge clk);
            #1;
        end
        recv_val = 1'b0;
        if (!fired) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic group(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] c, input logic [N-1:0] e,
                         input logic [N-1:0] exp_msg, input logic exp_sat,
                         input bit gaps);
        logic [N-1:0] v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = e;
        exp_q.push_back({exp_sat, exp_msg});
        for (int i = 0; i < LEN; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(posedge clk);
            #0 push(v[i]);
        end
    endtask

    // Monitor: pops the scoreboard on each send fire and watches the stall contract.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall <= 1'b0;
        end else begin
            chk("rdy_excl_val", {62'd0, recv_rdy, send_val}, {62'd0, !send_val, send_val});
            if (prev_stall) begin
                chk("stall_val", {63'd0, send_val}, 64'd1);
                chk("stall_msg", {31'd0, send_sat, send_msg}, {31'd0, prev_sat, prev_msg});
            end
            if (send_val && send_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {31'd0, send_sat, send_msg}, 64'd0);
                end else begin
                    logic [N:0] e;
                    e = exp_q.pop_front();
                    chk("sum", {32'd0, send_msg}, {32'd0, e[N-1:0]});
                    chk("sat", {63'd0, send_sat}, {63'd0, e[N]});
                end
            end
            prev_stall <= send_val && !send_rdy;
            prev_msg   <= send_msg;
            prev_sat   <= send_sat;
        end
    end

    initial begin
        reset    = 1'b1;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b1;

        // Asynchronous reset between edges
        #3 reset = 1'b0;
        #1;
        chk("rst_recv_rdy", {63'd0, recv_rdy}, 64'd1);
        chk("rst_send_val", {63'd0, send_val}, 64'd0);
        chk("rst_send_msg", {32'd0, send_msg}, 64'd0);
        chk("rst_send_sat", {63'd0, send_sat}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Basic group, back-to-back, with latency check
        group(32'h0001_0000, 32'h0002_0000, 32'hFFFF_8000, 32'h0000_8000,
              32'h0003_0000, 1'b0, 1'b0);
        chk("lat_send_val", {63'd0, send_val}, 64'd1);
        chk("lat_recv_rdy", {63'd0, recv_rdy}, 64'd0);
        @(posedge clk);
        #1;
        chk("one_cycle_val", {63'd0, send_val}, 64'd0);

        group(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
              32'h7FFF_FFFF, 1'b1, 1'b0);
        group(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
              32'h8000_0000, 1'b1, 1'b0);
        group(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
              32'hFFFF_FFFE, 1'b0, 1'b0);

        // Stalled downstream with gapped upstream
        @(posedge clk);
        #1 send_rdy = 1'b0;
        group(32'h0005_0000, 32'h0003_0000, 32'hFFFE_0000, 32'h0000_0001,
              32'h0006_0001, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_recv_rdy", {63'd0, recv_rdy}, 64'd0);
            @(posedge clk);
            #1;
        end
        send_rdy = 1'b1;
        group(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
              32'h0004_0000, 1'b0, 1'b1);

        // Reset mid-group discards the partial sum
        @(posedge clk);
        #1;
        push(32'h0100_0000);
        push(32'h0200_0000);
        #2 reset = 1'b0;
        #1;
        chk("midrst_send_val", {63'd0, send_val}, 64'd0);
        chk("midrst_recv_rdy", {63'd0, recv_rdy}, 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        group(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004,
              32'h0000_000A, 1'b0, 1'b0);

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fixed_point_accumulator.md
# fixed_point_accumulator

Downstream stage of the fixed-point iterative multiplier. Consumes a stream of signed Qn.d products on a val/rdy interface, sums each group of `len` consecutive products in a widened accumulator, and emits one saturated n-bit Qn.d sum per group. Together with the multiplier, it forms a dot-product datapath: the multiplier's send side connects directly to this block's recv side.

## Interface
- `n`, 32, word width of products and result (signed two's complement)
- `d`, 16, fractional bits. Defines the Qn.d format only; has no arithmetic effect because all terms share one format.
- `len`, 8, products per output sum; legal range 1..256
- `clk`  input  1  sole clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-low; 0 clears all state immediately, independent of `clk`
- `recv_val`  input  1  upstream product valid
- `recv_rdy`  output  1  block can accept a product
- `recv_msg`  input  n  signed Qn.d product
- `send_val`  output  1  sum valid
- `send_rdy`  input  1  downstream accepts sum
- `send_msg`  output  n  saturated signed Qn.d sum
- `send_sat`  output  1  1 if `send_msg` was clipped; meaningful only while `send_val`=1

## Operation
- Accumulator `acc` width w = n + clog2(len) + 1, signed. Counter `cnt` width clog2(len)+1.
- States:
  - ACC: `recv_rdy`=1, `send_val`=0.
  - DONE: `recv_rdy`=0, `send_val`=1.
- ACC, recv fire (`recv_val`&&`recv_rdy`):
  - `acc` <= `acc` + sign_extend(`recv_msg`, w); `cnt` <= `cnt`+1.
  - If `cnt`==len-1, go to DONE and register the saturated result into `send_msg`/`send_sat`.
  - `acc`/`cnt` then hold until the send fire.
- ACC, no fire: hold all state.
- DONE, send fire (`send_val`&&`send_rdy`): `acc`<=0, `cnt`<=0, go to ACC.
- DONE, no fire: `send_msg`, `send_sat`, `send_val` held stable. Upstream stalls via `recv_rdy`=0.
- Saturation, applied to the full w-bit final sum S:
  - S > 2^(n-1)-1: `send_msg` = 0x7FFF_FFFF (n=32), `send_sat`=1.
  - S < -2^(n-1): `send_msg` = 0x8000_0000, `send_sat`=1.
  - Otherwise: `send_msg` = S[n-1:0], `send_sat`=0.
- Intermediate partial sums never saturate; only the final group sum is clipped. This makes the result order-independent.
- `len`=1: every accepted product goes straight to DONE. The output is the product itself with `send_sat`=0.

## Timing
- Reset (`reset`=0), asynchronous:
  - state=ACC, `acc`=0, `cnt`=0.
  - `recv_rdy`=1, `send_val`=0, `send_msg`=0, `send_sat`=0.
- Reset asserted mid-group or in DONE: the partial sum or pending result is discarded with no output. After release, the next accepted product starts a fresh group.
- Latency: `send_val` rises the cycle after the cycle in which the len-th product fires.
- Throughput: a group needs at least len+1 cycles (len accept cycles plus ≥1 DONE cycle). No overlap of send and recv.
- `recv_rdy` and `send_val` are pure functions of state; no combinational path from `send_rdy` to `recv_rdy`, or from `recv_val` to `send_val`.
- `recv_val` deasserted mid-group: `cnt`/`acc` hold; gaps of any length are allowed.
- `recv_val`=1 while in DONE: ignored (no fire). The upstream must hold its message per the val/rdy rules.
- `send_rdy`=1 during ACC: no effect.

## Test plan
- Reset sanity: assert `reset`=0 mid-clock, no edge needed -> outputs are 0 immediately; `recv_rdy`=1, `send_val`=0.
- Basic group (n=32, d=16, len=4): feed 0x00010000, 0x00020000, 0xFFFF8000, 0x00008000 back-to-back with `send_rdy`=1.
  - `send_msg`=0x00030000, `send_sat`=0.
  - `send_val` is high exactly one cycle, the cycle after the 4th fire.
  - `recv_rdy`=0 during that cycle.
- Positive saturation (len=4): feed 4× 0x40000000 -> `send_msg`=0x7FFFFFFF, `send_sat`=1.
- Negative saturation (len=4): feed 4× 0x80000000 -> `send_msg`=0x80000000, `send_sat`=1.
- Order independence (len=4): feed 0x7FFFFFFF, 0x7FFFFFFF, 0x80000000, 0x80000000 -> `send_msg`=0xFFFFFFFE, `send_sat`=0. Intermediate overflow must not clip.
- Backpressure and stalls: random `recv_val` gaps and `send_rdy` held 0 for 5 cycles.
  - `send_msg` stable while stalled; `recv_rdy`=0 throughout the stall.
  - Next group sums correctly with no carry-over.
  - Then assert reset after 2 of 4 products -> no output; the following full group sums from zero.
